// File: rtl/tmr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tmr_pkg                                                                    |
// | Register map, control bit positions and FSM states for tmr_sched.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package tmr_pkg;

    localparam logic [1:0] REG_CNT  = 2'd0;
    localparam logic [1:0] REG_CTL  = 2'd1;
    localparam logic [1:0] REG_PEND = 2'd2;
    localparam logic [1:0] REG_RSV  = 2'd3;

    localparam int CTL_EN   = 0;
    localparam int CTL_PER  = 1;
    localparam int CTL_IE   = 2;
    localparam int CTL_EXP  = 3;
    localparam int PEND_OVR = 31;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/tmr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tmr_sched                                                                  |
// | Millisecond alarm scheduler: one decrementer time-shared over NUM_CH       |
// | one-shot/periodic channels, sticky expiry flags and a level interrupt.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tmr_sched
    import tmr_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 16,
    localparam int AW     = $clog2(NUM_CH) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ms_tick,
    input  logic          stb,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   data_in,
    output logic [31:0]   data_out,
    output logic          ack,
    output logic          irq
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     idx_q, idx_d;
    logic                tick_pend_q, tick_pend_d;
    logic                ovr_q, ovr_d;
    logic [CNT_W-1:0]    cnt_q    [NUM_CH];
    logic [CNT_W-1:0]    cnt_d    [NUM_CH];
    logic [CNT_W-1:0]    reload_q [NUM_CH];
    logic [CNT_W-1:0]    reload_d [NUM_CH];
    logic [NUM_CH-1:0]   en_q, en_d, per_q, per_d, ie_q, ie_d, exp_q, exp_d;
    logic [31:0]         data_out_q, data_out_d;
    logic                ack_q, ack_d;
    logic                irq_q, irq_d;

    logic [1:0]          w_reg;
    logic [CH_W-1:0]     w_ch;
    logic                w_ch_ok;
    logic                w_wr;
    logic [CNT_W-1:0]    w_cur_cnt;
    logic [CNT_W-1:0]    w_dec;
    logic                w_scan_act;
    logic                w_cnt_coll;
    logic                w_scan_upd;
    logic                w_hit;
    logic [31:0]         w_rd;
    logic                w_unused_data;

    assign w_unused_data = ^data_in;

    always_comb begin
        w_reg      = addr[1:0];
        w_ch       = CH_W'(addr >> 2);
        w_ch_ok    = (32'(w_ch) < NUM_CH);
        w_wr       = stb && wr;
        w_cur_cnt  = cnt_q[idx_q];
        w_dec      = w_cur_cnt - CNT_W'(1);
        w_hit      = (w_dec == '0);
        w_scan_act = (state_q == ST_SCAN) && en_q[idx_q] && (w_cur_cnt != '0);
        // A counter write to the channel under scan discards that scan step entirely
        w_cnt_coll = w_wr && (w_reg == REG_CNT) && w_ch_ok && (w_ch == idx_q);
        w_scan_upd = w_scan_act && !w_cnt_coll;
    end

    always_comb begin
        w_rd = '0;
        case (w_reg)
            REG_CNT: if (w_ch_ok) w_rd = 32'(cnt_q[w_ch]);
            REG_CTL: if (w_ch_ok) w_rd = {28'b0, exp_q[w_ch], ie_q[w_ch], per_q[w_ch], en_q[w_ch]};
            REG_PEND: begin
                w_rd[NUM_CH-1:0] = exp_q;
                w_rd[PEND_OVR]   = ovr_q;
            end
            default: w_rd = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tick_pend_d = tick_pend_q;
        ovr_d       = ovr_q;
        cnt_d       = cnt_q;
        reload_d    = reload_q;
        en_d        = en_q;
        per_d       = per_q;
        ie_d        = ie_q;
        exp_d       = exp_q;
        ack_d       = stb;
        data_out_d  = (stb && !wr) ? w_rd : data_out_q;
        irq_d       = |(exp_q & ie_q);

        if (w_scan_upd) begin
            if (!w_hit) begin
                cnt_d[idx_q] = w_dec;
            end else begin
                cnt_d[idx_q] = (per_q[idx_q] && reload_q[idx_q] != '0) ? reload_q[idx_q] : '0;
                if (!per_q[idx_q]) en_d[idx_q] = 1'b0;
            end
        end

        if (w_wr) begin
            case (w_reg)
                REG_CNT: if (w_ch_ok) begin
                    cnt_d[w_ch]    = data_in[CNT_W-1:0];
                    reload_d[w_ch] = data_in[CNT_W-1:0];
                end
                REG_CTL: if (w_ch_ok) begin
                    en_d[w_ch]  = data_in[CTL_EN];
                    per_d[w_ch] = data_in[CTL_PER];
                    ie_d[w_ch]  = data_in[CTL_IE];
                    if (data_in[CTL_EXP]) exp_d[w_ch] = 1'b0;
                end
                REG_PEND: if (data_in[PEND_OVR]) ovr_d = 1'b0;
                default: ;
            endcase
        end

        // Expiry is applied after the CPU clear so a coincident new expiry survives
        if (w_scan_upd && w_hit) exp_d[idx_q] = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (ms_tick || tick_pend_q) begin
                    state_d     = ST_SCAN;
                    idx_d       = '0;
                    tick_pend_d = tick_pend_q && ms_tick;
                end
            end
            ST_SCAN: begin
                if (ms_tick) begin
                    if (tick_pend_q) ovr_d = 1'b1;
                    else             tick_pend_d = 1'b1;
                end
                if (idx_q == CH_W'(NUM_CH - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tick_pend_q <= 1'b0;
            ovr_q       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                reload_q[i] <= '0;
            end
            en_q        <= '0;
            per_q       <= '0;
            ie_q        <= '0;
            exp_q       <= '0;
            data_out_q  <= '0;
            ack_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tick_pend_q <= tick_pend_d;
            ovr_q       <= ovr_d;
            cnt_q       <= cnt_d;
            reload_q    <= reload_d;
            en_q        <= en_d;
            per_q       <= per_d;
            ie_q        <= ie_d;
            exp_q       <= exp_d;
            data_out_q  <= data_out_d;
            ack_q       <= ack_d;
            irq_q       <= irq_d;
        end
    end

    assign data_out = data_out_q;
    assign ack      = ack_q;
    assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_tmr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tmr_sched                                                               |
// | Directed and random stimulus against a tick-schedule reference model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tmr_sched;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int AW     = 4;
    localparam int MASK   = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ms_tick = 1'b0;
    logic          stb = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   data_in = '0;
    logic [31:0]   data_out;
    logic          ack;
    logic          irq;

    tmr_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .ms_tick (ms_tick),
        .stb     (stb),
        .wr      (wr),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .ack     (ack),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: channel i of a scan that starts with base b is serviced at cycle b+i
    int          m_cnt [NUM_CH];
    int          m_rel [NUM_CH];
    bit          m_en  [NUM_CH];
    bit          m_per [NUM_CH];
    bit          m_ie  [NUM_CH];
    bit          m_exp [NUM_CH];
    bit          m_ovr, m_pend, m_ack, m_irq;
    logic [31:0] m_dout;
    int          m_base;
    int          cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] m_read(input int ch, input int rg);
        logic [31:0] v = '0;
        case (rg)
            0: v = 32'(m_cnt[ch]);
            1: v = {28'b0, m_exp[ch], m_ie[ch], m_per[ch], m_en[ch]};
            2: begin
                for (int i = 0; i < NUM_CH; i++) v[i] = m_exp[i];
                v[31] = m_ovr;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0;
            m_en[i] = 0; m_per[i] = 0; m_ie[i] = 0; m_exp[i] = 0;
        end
        m_ovr = 0; m_pend = 0; m_ack = 0; m_irq = 0; m_dout = '0; m_base = -1;
    endtask

    task automatic model_step(input bit t, input bit s, input bit w,
                              input int ch, input int rg, input logic [31:0] d);
        bit in_scan, set_exp, irq_next;
        int i;
        in_scan  = (m_base >= 0) && (cyc >= m_base) && (cyc < m_base + NUM_CH);
        i        = cyc - m_base;
        irq_next = 0;
        for (int k = 0; k < NUM_CH; k++) irq_next |= m_exp[k] & m_ie[k];
        if (s && !w) m_dout = m_read(ch, rg);
        m_ack   = s;
        set_exp = 0;
        if (in_scan && !(s && w && rg == 0 && ch == i) && m_en[i] && m_cnt[i] != 0) begin
            m_cnt[i] = m_cnt[i] - 1;
            if (m_cnt[i] == 0) begin
                set_exp = 1;
                if (m_per[i] && m_rel[i] != 0) m_cnt[i] = m_rel[i];
                if (!m_per[i]) m_en[i] = 0;
            end
        end
        if (s && w) begin
            case (rg)
                0: begin m_cnt[ch] = int'(d) & MASK; m_rel[ch] = int'(d) & MASK; end
                1: begin
                    m_en[ch] = d[0]; m_per[ch] = d[1]; m_ie[ch] = d[2];
                    if (d[3]) m_exp[ch] = 0;
                end
                2: if (d[31]) m_ovr = 0;
                default: ;
            endcase
        end
        if (set_exp) m_exp[i] = 1;
        if (in_scan) begin
            if (t) begin
                if (m_pend) m_ovr = 1;
                else        m_pend = 1;
            end
        end else if (t || m_pend) begin
            m_base = cyc + 1;
            m_pend = m_pend && t;
        end
        m_irq = irq_next;
    endtask

    task automatic step(input bit t, input bit s, input bit w, input int ch, input int rg,
                        input logic [31:0] d, input bit r);
        ms_tick = t; stb = s; wr = w; addr = AW'((ch << 2) | rg); data_in = d; rst = r;
        if (r) model_reset();
        else   model_step(t, s, w, ch, rg, d);
        @(posedge clk);
        #1;
        cyc++;
        check_val("ack", {31'b0, ack}, {31'b0, m_ack});
        check_val("data_out", data_out, m_dout);
        check_val("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 32'h0, 0);
    endtask
    task automatic tick();
        step(1, 0, 0, 0, 0, 32'h0, 0);
    endtask
    task automatic wr_reg(input int ch, input int rg, input logic [31:0] d);
        step(0, 1, 1, ch, rg, d, 0);
    endtask
    task automatic rd_reg(input int ch, input int rg);
        step(0, 1, 0, ch, rg, 32'h0, 0);
    endtask

    int per_exp [6] = '{1, 2, 1, 2, 1, 2};

    initial begin
        model_reset();
        step(0, 0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        check_val("rst_ack", {31'b0, ack}, 32'h0);
        check_val("rst_dout", data_out, 32'h0);
        check_val("rst_irq", {31'b0, irq}, 32'h0);
        idle(2);

        // One-shot with interrupt
        wr_reg(0, 0, 32'd3);
        wr_reg(0, 1, 32'h5);
        for (int k = 0; k < 3; k++) begin tick(); idle(7); end
        check_val("os_irq", {31'b0, irq}, 32'h1);
        rd_reg(0, 0);
        check_val("os_cnt", data_out, 32'h0);
        rd_reg(0, 1);
        check_val("os_ctl", data_out, 32'hC);
        wr_reg(0, 1, 32'hC);
        idle(1);
        check_val("os_irq_clr", {31'b0, irq}, 32'h0);

        // Periodic
        wr_reg(1, 0, 32'd2);
        wr_reg(1, 1, 32'h3);
        for (int k = 0; k < 6; k++) begin
            tick(); idle(6);
            rd_reg(1, 0);
            check_val("per_cnt", data_out, 32'(per_exp[k]));
        end
        rd_reg(0, 2);
        check_val("per_pend", data_out, 32'h2);
        wr_reg(1, 1, 32'h8);

        // Scan latency: pend polled every cycle by the model comparison
        for (int c = 0; c < NUM_CH; c++) begin wr_reg(c, 0, 32'd1); wr_reg(c, 1, 32'h1); end
        step(1, 1, 0, 0, 2, 32'h0, 0);
        for (int k = 0; k < 6; k++) rd_reg(0, 2);
        check_val("lat_pend", data_out, 32'hF);
        for (int c = 0; c < NUM_CH; c++) wr_reg(c, 1, 32'h8);

        // Tick overrun
        wr_reg(0, 0, 32'd5);
        wr_reg(0, 1, 32'h1);
        tick(); tick(); tick();
        idle(12);
        rd_reg(0, 0);
        check_val("ovr_cnt", data_out, 32'd3);
        rd_reg(0, 2);
        check_val("ovr_pend", data_out, 32'h8000_0000);
        wr_reg(0, 2, 32'h8000_0000);
        rd_reg(0, 2);
        check_val("ovr_clr", data_out, 32'h0);
        wr_reg(0, 1, 32'h8);

        // CPU counter write collides with the scan of ch2
        wr_reg(2, 0, 32'd5);
        wr_reg(2, 1, 32'h1);
        tick(); idle(2);
        wr_reg(2, 0, 32'd10);
        idle(4);
        rd_reg(2, 0);
        check_val("coll_cnt", data_out, 32'd10);
        wr_reg(2, 1, 32'h8);

        // W1C collides with a new expiry on ch3
        wr_reg(3, 0, 32'd1);
        wr_reg(3, 1, 32'h3);
        tick(); idle(6);
        tick(); idle(3);
        wr_reg(3, 1, 32'hB);
        idle(4);
        rd_reg(3, 1);
        check_val("coll_w1c", data_out, 32'hB);

        // Reset in the middle of a scan
        tick(); idle(1);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        idle(1);
        for (int c = 0; c < NUM_CH; c++) begin
            rd_reg(c, 0); check_val("mrst_cnt", data_out, 32'h0);
            rd_reg(c, 1); check_val("mrst_ctl", data_out, 32'h0);
        end
        rd_reg(0, 2);
        check_val("mrst_pend", data_out, 32'h0);
        check_val("mrst_irq", {31'b0, irq}, 32'h0);
        tick(); idle(6);
        rd_reg(3, 0);
        check_val("mrst_tick", data_out, 32'h0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            bit t, s, w, r;
            int a;
            logic [31:0] d;
            t = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 1) == 1);
            w = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 599) == 0);
            a = $urandom_range(0, 15);
            case (a & 3)
                0:       d = 32'($urandom_range(0, 4));
                1:       d = 32'($urandom_range(0, 15));
                default: d = $urandom;
            endcase
            step(t, s, w, a >> 2, a & 3, d, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
